jt49_eg_gen: RTL and testbench

Parametrised envelope generator for the jt49 PSG family. It generalises gain resolution to GW bits (4 for AY-3-8910, 5 for YM2149) and integrates the envelope period counter, so the block produces its own step ticks from the core clock-enable. The envelope shape is latched on an explicit restart strobe, which is issued on every write to the shape register. The block sits between the register file and the per-channel amplitude mux; its gain output replaces the fixed level whenever a channel selects envelope mode.

---
 rtl/jt49_eg_gen.sv | 93 +++++++++
 tb/tb_jt49_eg_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jt49_eg_gen.sv
// Purpose: PSG envelope generator with built-in period counter; GW-bit gain, shape latched on restart.
// Latency: gain/step update on the clk edge after the tick condition; first ramp value 1 cycle after restart.
// Backpressure: none; free-running, advances only on cen ticks.
//
// Ports:
//   clk, rst      core clock, asynchronous active-high reset
//   cen           clock enable for the period counter
//   period        envelope period in cen ticks (0 behaves as 1)
//   ctrl          shape {CONT,ATT,ALT,HOLD}, sampled only on restart
//   restart       single-cycle strobe from a shape register write
//   gain          envelope level
//   step          one-cycle pulse on every envelope step
//   done          high while the envelope is frozen (held, finished, or never started)
module jt49_eg_gen #(
  parameter int GW = 5,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [PW-1:0] period,
  input  logic [3:0]    ctrl,
  input  logic          restart,
  output logic [GW-1:0] gain,
  output logic          step,
  output logic          done
);

  localparam logic [GW-1:0] MAX = '1;

  logic [PW-1:0] cnt;
  logic          dir;
  logic [3:0]    shape;
  // Set by the first restart after reset; keeps the counter (and so step)
  // quiet while the block is idle out of reset.
  logic          run;

  logic          cont, att, alt, hold;
  logic [PW-1:0] per_m1;
  logic          tick;
  logic          ramp_end;

  assign cont = shape[3];
  assign att  = shape[2];
  assign alt  = shape[1];
  assign hold = shape[0];

  // A period of 0 counts like a period of 1.
  assign per_m1   = (period == '0) ? '0 : period - PW'(1);
  assign tick     = cen & run & (cnt >= per_m1);
  assign ramp_end = dir ? (gain == MAX) : (gain == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gain  <= '0;
      step  <= 1'b0;
      done  <= 1'b1;
      cnt   <= '0;
      dir   <= 1'b0;
      shape <= 4'd0;
      run   <= 1'b0;
    end else if (restart) begin
      // Restart overrides any tick landing on the same edge.
      shape <= ctrl;
      cnt   <= '0;
      dir   <= ctrl[2];
      done  <= 1'b0;
      gain  <= ctrl[2] ? '0 : MAX;
      step  <= 1'b0;
      run   <= 1'b1;
    end else begin
      step <= tick;
      if (cen && run)
        cnt <= tick ? '0 : cnt + PW'(1);
      if (tick && !done) begin
        if (ramp_end && !cont) begin
          gain <= '0;
          done <= 1'b1;
        end else if (ramp_end && hold) begin
          gain <= alt ? ~gain : gain;
          done <= 1'b1;
        end else if (ramp_end && alt) begin
          // Triangle: turn around, extreme value is output for two steps.
          dir <= ~dir;
        end else begin
          // Normal ramp step; at a ramp end this is the sawtooth wrap.
          gain <= dir ? gain + GW'(1) : gain - GW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_jt49_eg_gen.sv
module tb_jt49_eg_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b1;
  logic [15:0] period = 16'd1;
  logic [3:0]  ctrl = 4'd0;
  logic        restart = 1'b0;

  logic [3:0]  gain4;
  logic        step4, done4;
  logic [4:0]  gain5;
  logic        step5, done5;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_no = 0;
  int cen_mode = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  jt49_eg_gen #(.GW(4), .PW(16)) dut4 (
    .clk(clk), .rst(rst), .cen(cen), .period(period), .ctrl(ctrl),
    .restart(restart), .gain(gain4), .step(step4), .done(done4)
  );

  jt49_eg_gen #(.GW(5), .PW(16)) dut5 (
    .clk(clk), .rst(rst), .cen(cen), .period(period), .ctrl(ctrl),
    .restart(restart), .gain(gain5), .step(step5), .done(done5)
  );

  // Envelope level as a closed-form function of the number of steps n taken
  // since restart.
  function automatic int env_gain(int gw, logic [3:0] sh, int n);
    int len, mx, p, q;
    bit cont, att, alt, hold;
    len = 1 << gw;
    mx = len - 1;
    cont = sh[3]; att = sh[2]; alt = sh[1]; hold = sh[0];
    if (n < len) return att ? n : mx - n;
    if (!cont) return 0;
    if (hold) return (att ^ alt) ? mx : 0;
    if (alt) begin
      p = n % (2 * len);
      if (p < len) return att ? p : mx - p;
      q = p - len;
      return att ? mx - q : q;
    end
    p = n % len;
    return att ? p : mx - p;
  endfunction

  function automatic int env_done(int gw, logic [3:0] sh, int n);
    if (sh[3] && !sh[0]) return 0;
    return (n >= (1 << gw)) ? 1 : 0;
  endfunction

  // Reference state: steps since restart, latched shape, counter position.
  int         m_cnt = 0;
  int         m_n = 0;
  logic [3:0] m_sh = 4'd0;
  bit         m_run = 1'b0;
  bit         m_step = 1'b0;

  always @(posedge clk or posedge rst) begin
    int pm;
    if (rst) begin
      m_run = 0; m_cnt = 0; m_n = 0; m_sh = 4'd0; m_step = 0;
    end else if (restart) begin
      m_run = 1; m_sh = ctrl; m_cnt = 0; m_n = 0; m_step = 0;
    end else begin
      m_step = 0;
      if (cen && m_run) begin
        pm = (period == 16'd0) ? 1 : int'(period);
        if (m_cnt >= pm - 1) begin
          m_cnt = 0; m_step = 1; m_n = m_n + 1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("gain4", int'(gain4), m_run ? env_gain(4, m_sh, m_n) : 0);
      check("done4", int'(done4), m_run ? env_done(4, m_sh, m_n) : 1);
      check("step4", int'(step4), int'(m_step));
      check("gain5", int'(gain5), m_run ? env_gain(5, m_sh, m_n) : 0);
      check("done5", int'(done5), m_run ? env_done(5, m_sh, m_n) : 1);
      check("step5", int'(step5), int'(m_step));
    end
  end

  task automatic cyc(int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      cyc_no++;
      restart = 1'b0;
      case (cen_mode)
        0:       cen = 1'b1;
        1:       cen = cyc_no[0];
        default: cen = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic pulse(logic [3:0] c);
    ctrl = c;
    restart = 1'b1;
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int k, nsteps;

    // Model pins against hand-computed values.
    check("pin_E16", env_gain(4, 4'hE, 16), 15);
    check("pin_E17", env_gain(4, 4'hE, 17), 14);
    check("pin_E33", env_gain(4, 4'hE, 33), 1);
    check("pin_B16", env_gain(4, 4'hB, 16), 15);
    check("pin_8_32", env_gain(5, 4'h8, 32), 31);
    check("pin_0_done", env_done(4, 4'h0, 16), 1);

    cyc(3);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_gain", int'(gain4), 0);
    check("rst_done", int'(done4), 1);
    check("rst_step", int'(step4), 0);

    // Single decay, period 1.
    period = 16'd1;
    pulse(4'h0);
    check("s0_first", int'(gain4), 15);
    check("s0_first_done", int'(done4), 0);
    cyc(40);
    check("s0_end_gain", int'(gain4), 0);
    check("s0_end_done", int'(done4), 1);

    // Triangle.
    pulse(4'hE);
    cyc(80);
    check("sE_done", int'(done4), 0);

    // Decay then hold high; attack and hold high.
    pulse(4'hB);
    cyc(40);
    check("sB_gain", int'(gain4), 15);
    check("sB_done", int'(done4), 1);
    pulse(4'hD);
    cyc(40);
    check("sD_gain", int'(gain4), 15);
    check("sD_done", int'(done4), 1);

    // Sawtooth, period 3, cen every other clock.
    period = 16'd3;
    cen_mode = 1;
    pulse(4'h8);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      if (step5) found = 1;
    end
    check("s8_first_step", int'(found), 1);
    k = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(1);
      k++;
      if (step5) found = 1;
    end
    check("s8_step_interval", k, 6);
    cyc(230);
    cen_mode = 0;

    // Period 0 counts as period 1.
    period = 16'd0;
    pulse(4'hE);
    cyc(1);
    check("p0_step_a", int'(step4), 1);
    check("p0_gain_a", int'(gain4), 1);
    cyc(1);
    check("p0_step_b", int'(step4), 1);
    check("p0_gain_b", int'(gain4), 2);
    cyc(30);

    // Asynchronous reset mid-ramp.
    period = 16'd2;
    pulse(4'hE);
    cyc(10);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_gain", int'(gain4), 0);
    check("arst_done", int'(done4), 1);
    check("arst_step", int'(step4), 0);
    cyc(2);
    rst = 1'b0;
    nsteps = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (step4) nsteps++;
    end
    check("idle_no_step", nsteps, 0);

    // Restart colliding with a tick at gain 7.
    pulse(4'hE);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(1);
      if (step4 && gain4 == 4'd7) found = 1;
    end
    check("wait_g7", int'(found), 1);
    cyc(1);
    pulse(4'hC);
    check("rt_gain", int'(gain4), 0);
    check("rt_step", int'(step4), 0);
    check("rt_done", int'(done4), 0);
    cyc(1);
    check("rt_gain_b", int'(gain4), 0);
    check("rt_step_b", int'(step4), 0);
    cyc(1);
    check("rt_gain_c", int'(gain4), 1);
    check("rt_step_c", int'(step4), 1);

    // Randomized traffic.
    cen_mode = 2;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        pulse(4'($urandom_range(0, 15)));
      end else begin
        if ($urandom_range(0, 59) == 0) period = 16'($urandom_range(0, 3));
        if ($urandom_range(0, 49) == 0) ctrl = 4'($urandom_range(0, 15));
        cyc(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
